multitrafficlights: RTL and testbench
=====================================

# multitrafficlights

Parametrised N-way intersection controller that succeeds the fixed two-way traffic-light block. It serves vehicle requests round-robin with configurable green, yellow and all-red clearance durations. It skips idle approaches, extends green when uncontested, and offers a flashing-yellow night mode. It sits at the top of the traffic-light subsystem and drives the lamp outputs directly.

## Interface
- N_WAYS, 4: number of approaches, 2..8.
- GREEN_CYCLES, 8: green duration in cycles, ≥1.
- YELLOW_CYCLES, 2: yellow duration in cycles, ≥1.
- ALLRED_CYCLES, 1: all-red clearance duration in cycles, ≥1.
- FLASH_HALF, 4: night-mode half-period in cycles, ≥1.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_WAYS  level-sensitive vehicle-present sensor per way.
- night  in  1  night-mode request, level-sensitive.
- lights  out  3*N_WAYS  per-way lamps; way i is bits [3i+2:3i], encoded {red, yellow, green}.
- active  out  $clog2(N_WAYS)  index of the way currently holding or last holding right-of-way.

## Operation
- Lamp codes: RED=100, YELLOW=010, GREEN=001, DARK=000.
- States: ALLRED, GREEN, YELLOW, FLASH. There is one down-counter, sized for the largest duration.
- Reset (rst=0):
  - state=ALLRED, counter=ALLRED_CYCLES, ptr=N_WAYS-1, so way 0 wins first.
  - All ways show RED; active=N_WAYS-1.
- ALLRED, on counter expiry:
  - night=1 → FLASH.
  - Otherwise, any req → GREEN on the first way i with req[i]=1, scanning ptr+1, ptr+2, …, ptr (mod N_WAYS). ptr is updated to i.
  - Otherwise, no req → stay ALLRED and hold all red. Re-evaluate every cycle.
- GREEN:
  - Way ptr shows GREEN; all other ways show RED.
  - On expiry, if req[ptr]=1, no other req is set and night=0 → restart GREEN_CYCLES (extension). Otherwise → YELLOW.
- YELLOW:
  - Way ptr shows YELLOW; all other ways show RED.
  - On expiry → ALLRED.
- FLASH:
  - All ways alternate YELLOW for FLASH_HALF cycles, then DARK for FLASH_HALF cycles, starting with YELLOW.
  - When night=0 at the end of a DARK half → ALLRED. ptr is unchanged.
- night during GREEN/YELLOW has no effect until the next ALLRED expiry. The safe sequence is never cut short.
- req changes mid-phase never shorten a phase. req is sampled only at ALLRED and GREEN expiry.
- Invariant outside FLASH: at most one way is non-RED.

## Timing
- lights and active are decoded from registered state only. There is no combinational path from req or night.
- Each phase lasts exactly its parameter in cycles, counted from the posedge that entered it.
- After rst deasserts, with req[0]=1: ALLRED_CYCLES cycles of all red, then way 0 GREEN.
- Decisions use req/night as sampled on the expiry posedge. The new state is visible the same edge.
- Asynchronous reset mid-phase forces all-RED immediately, with no waiting for yellow.
- A full serve cycle for one way is GREEN_CYCLES + YELLOW_CYCLES + ALLRED_CYCLES.

## Structure
- Package multitrafficlights_pkg holds:
  - the lamp code constants RED, YELLOW, GREEN, DARK;
  - the state enum {ALLRED, GREEN, YELLOW, FLASH};
  - a helper for counter width.
- Sub-module rr_pick: combinational round-robin search over req starting at ptr+1. It outputs found and idx, and is parametrised by N_WAYS.
- The top level contains the FSM, the down-counter, ptr, flash phase bit and lamp decode.

## Test plan
All scenarios use N_WAYS=4, GREEN_CYCLES=4, YELLOW_CYCLES=2, ALLRED_CYCLES=1, FLASH_HALF=2.

1. **Reset, no traffic.** Hold rst=0 for 2 cycles, then release with req=0000.
   - Required: lights=100100100100 throughout, active=3.
2. **Full rotation.** Release with req=1111.
   - Required: way 0 001 for 4 cycles, 010 for 2, then 1 cycle all red; then way 1, 2, 3 in order.
   - Required: the one-non-red invariant is never violated.
3. **Skip and repeat.** Hold req=0100.
   - Required: way 2 is green continuously (extended every 4 cycles), with no yellow.
   - Then raise req[0]. Required: way 2 goes to yellow at the next green expiry; way 0 is green 3 cycles later.
4. **Night mode.** Raise night mid-GREEN of way 1.
   - Required: green and yellow complete, then all red for 1 cycle.
   - Required: then all ways alternate 010 for 2 cycles and 000 for 2 cycles.
   - Drop night. Required: exit after the current DARK half, then ALLRED, then way 2 is served next.
5. **Reset mid-yellow.** Drive rst=0 asynchronously between edges during YELLOW.
   - Required: all 100 immediately; after release, the sequence restarts from way 0.

Source files
------------

// File: rtl/multitrafficlights_pkg.sv
// multitrafficlights_pkg: lamp codes, FSM state type and counter sizing
// helper shared by the N-way intersection controller.
package multitrafficlights_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_FLASH
    } state_t;

    function automatic int max4(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int cnt_width(input int maxv);
        return (maxv < 2) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/multitrafficlights_if.sv
// multitrafficlights_if: sensor inputs (req, night) and lamp outputs
// (lights, active); master = environment, slave = controller.
interface multitrafficlights_if #(
    parameter int N_WAYS = 4
);
    logic [N_WAYS-1:0]         req;
    logic                      night;
    logic [3*N_WAYS-1:0]       lights;
    logic [$clog2(N_WAYS)-1:0] active;

    modport master (
        output req,
        output night,
        input  lights,
        input  active
    );

    modport slave (
        input  req,
        input  night,
        output lights,
        output active
    );
endinterface

// File: rtl/multitrafficlights_rr_pick.sv
// rr_pick: combinational round-robin search of req starting at ptr+1.
// Ports: req, ptr in; found, idx out (idx = ptr when nothing found).
module rr_pick #(
    parameter int N_WAYS = 4
) (
    input  logic [N_WAYS-1:0]         req,
    input  logic [$clog2(N_WAYS)-1:0] ptr,
    output logic                      found,
    output logic [$clog2(N_WAYS)-1:0] idx
);
    localparam int PW = $clog2(N_WAYS);

    always_comb begin
        int w;
        w     = 0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 1; k <= N_WAYS; k++) begin
            w = (int'(ptr) + k) % N_WAYS;
            if (!found && req[w]) begin
                found = 1'b1;
                idx   = PW'(w);
            end
        end
    end
endmodule

// File: rtl/multitrafficlights.sv
// multitrafficlights: N-way round-robin traffic controller with night flash.
// Ports: clk, rst (async active-low), bus (slave: req/night in, lights/active out).
module multitrafficlights
    import multitrafficlights_pkg::*;
#(
    parameter int N_WAYS        = 4,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int FLASH_HALF    = 4
) (
    input logic                clk,
    input logic                rst,
    multitrafficlights_if.slave bus
);
    localparam int PW = $clog2(N_WAYS);
    localparam int CW = cnt_width(max4(GREEN_CYCLES, YELLOW_CYCLES,
                                       ALLRED_CYCLES, FLASH_HALF));

    localparam logic [CW-1:0] C_G = CW'(GREEN_CYCLES);
    localparam logic [CW-1:0] C_Y = CW'(YELLOW_CYCLES);
    localparam logic [CW-1:0] C_A = CW'(ALLRED_CYCLES);
    localparam logic [CW-1:0] C_F = CW'(FLASH_HALF);
    localparam logic [CW-1:0] C_1 = CW'(1);

    state_t          state, st_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic            dark, dark_n;

    logic            found;
    logic [PW-1:0]   idx;
    logic            expired;
    logic            solo;
    logic [N_WAYS-1:0] sel;

    rr_pick #(.N_WAYS(N_WAYS)) u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .found(found),
        .idx  (idx)
    );

    // Counter is loaded with a phase length and the phase ends when it
    // reads 1, so a phase lasts exactly its length in cycles.
    assign expired = (cnt == C_1);
    assign sel     = N_WAYS'(1) << ptr;
    // Uncontested: only the current way is requesting.
    assign solo    = (bus.req == sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_ALLRED;
            cnt   <= C_A;
            ptr   <= PW'(N_WAYS - 1);
            dark  <= 1'b0;
        end else begin
            state <= st_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            dark  <= dark_n;
        end
    end

    always_comb begin
        st_n   = state;
        cnt_n  = cnt - C_1;
        ptr_n  = ptr;
        dark_n = dark;
        case (state)
            S_ALLRED: begin
                if (expired) begin
                    if (bus.night) begin
                        st_n   = S_FLASH;
                        cnt_n  = C_F;
                        dark_n = 1'b0;
                    end else if (found) begin
                        st_n  = S_GREEN;
                        cnt_n = C_G;
                        ptr_n = idx;
                    end else begin
                        // Idle: stay expired and re-evaluate next cycle.
                        cnt_n = C_1;
                    end
                end
            end
            S_GREEN: begin
                if (expired) begin
                    if (solo && !bus.night) begin
                        cnt_n = C_G;
                    end else begin
                        st_n  = S_YELLOW;
                        cnt_n = C_Y;
                    end
                end
            end
            S_YELLOW: begin
                if (expired) begin
                    st_n  = S_ALLRED;
                    cnt_n = C_A;
                end
            end
            S_FLASH: begin
                if (expired) begin
                    cnt_n = C_F;
                    if (!dark) begin
                        dark_n = 1'b1;
                    end else if (!bus.night) begin
                        st_n   = S_ALLRED;
                        cnt_n  = C_A;
                        dark_n = 1'b0;
                    end else begin
                        dark_n = 1'b0;
                    end
                end
            end
            default: begin
                st_n  = S_ALLRED;
                cnt_n = C_A;
            end
        endcase
    end

    logic [3*N_WAYS-1:0] lamps;

    always_comb begin
        logic [2:0] lamp;
        lamp  = RED;
        lamps = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            lamp = RED;
            unique case (1'b1)
                (state == S_GREEN):
                    if (PW'(i) == ptr) lamp = GREEN;
                (state == S_YELLOW):
                    if (PW'(i) == ptr) lamp = YELLOW;
                (state == S_FLASH):
                    lamp = dark ? DARK : YELLOW;
                (state == S_ALLRED):
                    lamp = RED;
            endcase
            lamps[3*i +: 3] = lamp;
        end
    end

    assign bus.lights = lamps;
    assign bus.active = ptr;
endmodule

// File: tb/tb_multitrafficlights.sv
// tb_multitrafficlights: scoreboard bench; a phase-schedule model pushes
// expected frames per cycle, a negedge monitor pops and compares.
module tb_multitrafficlights;
    localparam int N = 4;
    localparam int G = 4;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int F = 2;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_D = 3'b000;
    localparam logic [11:0] ALL_RED = 12'b100100100100;

    typedef struct packed {
        logic [11:0] l;
        logic [1:0]  a;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multitrafficlights_if #(.N_WAYS(N)) bus ();

    multitrafficlights #(
        .N_WAYS       (N),
        .GREEN_CYCLES (G),
        .YELLOW_CYCLES(Y),
        .ALLRED_CYCLES(A),
        .FLASH_HALF   (F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    frame_t plan[$];
    frame_t exp_q[$];
    int     m_ptr;
    int     m_tag;

    // mode: 0 all red, 1 green on p, 2 yellow on p, 3 all yellow, 4 all dark
    function automatic frame_t mk(input int mode, input int p);
        frame_t f;
        logic [2:0] c;
        f.a = 2'(p);
        f.l = '0;
        for (int i = 0; i < N; i++) begin
            c = L_R;
            if (mode == 1 && i == p) c = L_G;
            if (mode == 2 && i == p) c = L_Y;
            if (mode == 3) c = L_Y;
            if (mode == 4) c = L_D;
            f.l[3*i +: 3] = c;
        end
        return f;
    endfunction

    task automatic push_phase(input int mode, input int p, input int n);
        for (int k = 0; k < n; k++) plan.push_back(mk(mode, p));
    endtask

    // Plan the next phase(s) once the current one has run out.
    task automatic decide();
        logic [N-1:0] r;
        logic         nt;
        bit           hit;
        r   = bus.req;
        nt  = bus.night;
        hit = 0;
        case (m_tag)
            0: begin
                if (nt) begin
                    push_phase(3, m_ptr, F);
                    push_phase(4, m_ptr, F);
                    m_tag = 3;
                end else if (r != 0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (!hit && r[(m_ptr + k) % N]) begin
                            hit = 1;
                            m_ptr = (m_ptr + k) % N;
                        end
                    end
                    push_phase(1, m_ptr, G);
                    m_tag = 1;
                end else begin
                    push_phase(0, m_ptr, 1);
                    m_tag = 0;
                end
            end
            1: begin
                if (r == (N'(1) << m_ptr) && !nt) begin
                    push_phase(1, m_ptr, G);
                end else begin
                    push_phase(2, m_ptr, Y);
                    m_tag = 2;
                end
            end
            2: begin
                push_phase(0, m_ptr, A);
                m_tag = 0;
            end
            default: begin
                if (!nt) begin
                    push_phase(0, m_ptr, A);
                    m_tag = 0;
                end else begin
                    push_phase(3, m_ptr, F);
                    push_phase(4, m_ptr, F);
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            exp_q.delete();
            m_ptr = N - 1;
            m_tag = 0;
            push_phase(0, m_ptr, A);
            exp_q.push_back(plan[0]);
        end else begin
            void'(plan.pop_front());
            if (plan.size() == 0) decide();
            exp_q.push_back(plan[0]);
        end
    end

    always @(negedge clk) begin
        frame_t e;
        if (!rst) begin
            checks++;
            if (bus.lights !== ALL_RED || bus.active !== 2'd3) begin
                errors++;
                $display("FAIL reset_hold lights=%b active=%0d want=%b/3",
                         bus.lights, bus.active, ALL_RED);
            end
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.lights !== e.l || bus.active !== e.a) begin
                errors++;
                $display("FAIL frame t=%0t lights=%b active=%0d want=%b/%0d",
                         $time, bus.lights, bus.active, e.l, e.a);
            end
        end
    end

    task automatic wait_lamp(input int way, input logic [2:0] code,
                             input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (way < 0) begin
                for (int i = 0; i < N; i++)
                    if (bus.lights[3*i +: 3] == code) hit = 1;
            end else if (bus.lights[3*way +: 3] == code) begin
                hit = 1;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s lamp=%b never seen", name, code);
        end
    endtask

    initial begin
        bus.req   = '0;
        bus.night = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        repeat (6) @(negedge clk);

        bus.req = 4'b1111;
        repeat (34) @(negedge clk);

        bus.req = 4'b0100;
        repeat (20) @(negedge clk);
        bus.req = 4'b0101;
        repeat (12) @(negedge clk);

        bus.req = 4'b1111;
        wait_lamp(1, L_G, "way1_green");
        bus.night = 1'b1;
        repeat (20) @(negedge clk);
        bus.night = 1'b0;
        repeat (16) @(negedge clk);

        wait_lamp(-1, L_Y, "yellow");
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.lights !== ALL_RED || bus.active !== 2'd3) begin
            errors++;
            $display("FAIL async_reset lights=%b active=%0d want=%b/3",
                     bus.lights, bus.active, ALL_RED);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.req = 4'($urandom);
            if ($urandom_range(0, 39) == 0) bus.night = ~bus.night;
        end
        bus.night = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
